// File: rtl/corelet_ctrl_if.sv
// Control/status bundle between corelet_ctrl and the corelet, xmem and pmem.
interface corelet_ctrl_if #(
  parameter int unsigned addr_w = 11
);
  logic              start;
  logic [7:0]        num_act;
  logic [3:0]        n_kij;
  logic [addr_w-1:0] w_base;
  logic [addr_w-1:0] a_base;
  logic              l0_o_full;
  logic              ofifo_o_valid;
  logic [33:0]       inst;
  logic              xmem_cen;
  logic [addr_w-1:0] xmem_addr;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [addr_w-1:0] pmem_addr;
  logic              pmem_wsel;
  logic              busy;
  logic              done;

  // Controller side.
  modport master (
    input  start, num_act, n_kij, w_base, a_base, l0_o_full, ofifo_o_valid,
    output inst, xmem_cen, xmem_addr, pmem_cen, pmem_wen, pmem_addr, pmem_wsel, busy, done
  );

  // Corelet / memory / host side.
  modport slave (
    output start, num_act, n_kij, w_base, a_base, l0_o_full, ofifo_o_valid,
    input  inst, xmem_cen, xmem_addr, pmem_cen, pmem_wen, pmem_addr, pmem_wsel, busy, done
  );
endinterface

// File: rtl/corelet_ctrl.sv
// Sequencer for the corelet: per pass loads a weight tile, streams activations and drains
// the OFIFO into pmem; a final phase accumulates the partial sums through the SFP.
module corelet_ctrl #(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned addr_w = 11
) (
  input logic            clk,
  input logic            reset,
  corelet_ctrl_if.master bus
);

  localparam int unsigned MaxRc = (row > col) ? row : col;
  localparam int unsigned CntW  = ($clog2(MaxRc + 1) > 8) ? $clog2(MaxRc + 1) : 8;
  localparam logic [CntW-1:0]   ColC   = CntW'(col);
  localparam logic [CntW-1:0]   ColM1  = CntW'(col - 1);
  localparam logic [addr_w-1:0] ColA   = addr_w'(col);

  typedef enum logic [2:0] {
    StIdle, StWFill, StWLoad, StGap, StAStream, StDrain, StAcc
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        k_q, k_d, nk_q, nk_d;
  logic [7:0]        na_q, na_d, o_q, o_d;
  logic [4:0]        ph_q, ph_d;
  logic              skid_q, skid_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]   lrd_cnt_q, lrd_cnt_d, l0_cnt_q, l0_cnt_d, d_cnt_q, d_cnt_d;

  logic              fetch, l0_wr, l0_rd, xrd, exec, drain;
  logic [CntW-1:0]   tgt, na_c;
  logic [4:0]        ph_last;
  logic [addr_w-1:0] k_a, na_a, o_a, x_base;

  // Skid, L0 occupancy and drain qualifiers shared by next-state and output logic.
  always_comb begin
    na_c    = CntW'(na_q);
    ph_last = 5'(nk_q) + 5'd1;
    k_a     = addr_w'(k_q);
    na_a    = addr_w'(na_q);
    o_a     = addr_w'(o_q);
    fetch   = (state_q == StWFill) || (state_q == StAStream);
    tgt     = (state_q == StWFill) ? ColC : na_c;
    l0_wr   = fetch && skid_q && !bus.l0_o_full;
    // Only fetch when the skid slot is free next cycle, so no returned word is ever dropped.
    xrd     = fetch && (rd_cnt_q < tgt) && (!skid_q || l0_wr);
    exec    = (state_q == StAStream) && (l0_cnt_q != '0) && (lrd_cnt_q < na_c);
    l0_rd   = exec || (state_q == StWLoad);
    drain   = ((state_q == StAStream) || (state_q == StDrain)) && bus.ofifo_o_valid &&
              (d_cnt_q < na_c);
    x_base  = (state_q == StWFill) ? bus.w_base + k_a * ColA : bus.a_base + k_a * na_a;
  end

  // Next-state and counter updates.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    nk_d      = nk_q;
    na_d      = na_q;
    o_d       = o_q;
    ph_d      = ph_q;
    skid_d    = xrd || (skid_q && !l0_wr);
    rd_cnt_d  = rd_cnt_q + CntW'(xrd);
    wr_cnt_d  = wr_cnt_q + CntW'(l0_wr);
    lrd_cnt_d = lrd_cnt_q;
    l0_cnt_d  = l0_cnt_q + CntW'(l0_wr) - CntW'(l0_rd);
    d_cnt_d   = d_cnt_q + CntW'(drain);
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          na_d      = (bus.num_act == 8'd0) ? 8'd1 : bus.num_act;
          nk_d      = (bus.n_kij == 4'd0) ? 4'd1 : bus.n_kij;
          k_d       = '0;
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          lrd_cnt_d = '0;
          l0_cnt_d  = '0;
          d_cnt_d   = '0;
          skid_d    = 1'b0;
          state_d   = StWFill;
        end
      end
      StWFill: begin
        if (l0_wr && (wr_cnt_q == ColM1)) begin
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          lrd_cnt_d = '0;
          state_d   = StWLoad;
        end
      end
      StWLoad: begin
        lrd_cnt_d = lrd_cnt_q + CntW'(1);
        if (lrd_cnt_q == ColM1) begin
          lrd_cnt_d = '0;
          state_d   = StGap;
        end
      end
      StGap: state_d = StAStream;
      StAStream: begin
        if (exec) lrd_cnt_d = lrd_cnt_q + CntW'(1);
        if (exec && (lrd_cnt_q == na_c - CntW'(1))) begin
          lrd_cnt_d = '0;
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        if (d_cnt_q == na_c) begin
          d_cnt_d = '0;
          k_d     = k_q + 4'd1;
          o_d     = '0;
          ph_d    = '0;
          state_d = (k_q == nk_q - 4'd1) ? StAcc : StWFill;
        end
      end
      StAcc: begin
        // ph 0..nk-1 read, 1..nk accumulate, nk+1 write back.
        ph_d = ph_q + 5'd1;
        if (ph_q == ph_last) begin
          ph_d = '0;
          o_d  = o_q + 8'd1;
          if (o_q == na_q - 8'd1) begin
            o_d     = '0;
            k_d     = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded outputs: inst bus, memory strobes and status.
  always_comb begin
    bus.inst       = '0;
    bus.inst[0]    = (state_q == StWLoad);
    bus.inst[1]    = exec;
    bus.inst[2]    = l0_wr;
    bus.inst[3]    = l0_rd;
    bus.inst[6]    = drain;
    bus.inst[33]   = (state_q == StAcc) && (ph_q != 5'd0) && (ph_q <= 5'(nk_q));
    bus.xmem_cen   = !xrd;
    bus.xmem_addr  = xrd ? x_base + addr_w'(rd_cnt_q) : '0;
    bus.pmem_cen   = 1'b1;
    bus.pmem_wen   = 1'b1;
    bus.pmem_addr  = '0;
    bus.pmem_wsel  = 1'b0;
    if (drain) begin
      bus.pmem_cen  = 1'b0;
      bus.pmem_wen  = 1'b0;
      bus.pmem_addr = k_a * na_a + addr_w'(d_cnt_q);
    end else if (state_q == StAcc) begin
      if (ph_q < 5'(nk_q)) begin
        bus.pmem_cen  = 1'b0;
        bus.pmem_addr = addr_w'(ph_q) * na_a + o_a;
      end else if (ph_q == ph_last) begin
        bus.pmem_cen  = 1'b0;
        bus.pmem_wen  = 1'b0;
        bus.pmem_wsel = 1'b1;
        bus.pmem_addr = addr_w'(nk_q) * na_a + o_a;
      end
    end
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StAcc) && (ph_q == ph_last) && (o_q == na_q - 8'd1);
  end

  // State register with synchronous reset; reset also discards any skid data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      k_q       <= '0;
      nk_q      <= '0;
      na_q      <= '0;
      o_q       <= '0;
      ph_q      <= '0;
      skid_q    <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      lrd_cnt_q <= '0;
      l0_cnt_q  <= '0;
      d_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      nk_q      <= nk_d;
      na_q      <= na_d;
      o_q       <= o_d;
      ph_q      <= ph_d;
      skid_q    <= skid_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      lrd_cnt_q <= lrd_cnt_d;
      l0_cnt_q  <= l0_cnt_d;
      d_cnt_q   <= d_cnt_d;
    end
  end

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Sequencing controller for the corelet and its two SRAMs: activation/weight memory (xmem) and psum memory (pmem). On `start` it runs `n_kij` passes. Each pass loads a `col`-vector weight tile through L0 into the MAC array, streams `num_act` activation vectors, and drains the output FIFO into pmem. A final accumulate phase reduces the per-pass partial sums through the SFP units and writes the results back to pmem. It is the only driver of the corelet `inst` bus.

## Interface
- `row`, 8: MAC array rows / L0 width in vectors
- `col`, 8: MAC array columns; weight vectors per tile
- `addr_w`, 11: xmem/pmem address width
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle pulse; sampled only in IDLE
- `num_act` in 8: activation vectors per pass; legal 1..255, 0 treated as 1
- `n_kij` in 4: number of passes; legal 1..15, 0 treated as 1
- `w_base` in addr_w: xmem base of weight tiles
- `a_base` in addr_w: xmem base of activations
- `l0_o_full` in 1: L0 cannot accept a write
- `ofifo_o_valid` in 1: OFIFO head holds a complete row
- `inst` out 34: bit map
  - [1:0] MAC {execute, load}
  - [2] L0 wr
  - [3] L0 rd
  - [6] OFIFO rd
  - [33] SFP acc
  - all other bits 0
- `xmem_cen` out 1: active-low read enable
- `xmem_addr` out addr_w: xmem read address
- `pmem_cen` out 1: active-low enable
- `pmem_wen` out 1: active-low write enable
- `pmem_addr` out addr_w: pmem address
- `pmem_wsel` out 1: pmem write-data select; 0 = OFIFO out, 1 = SFP results
- `busy` out 1: high in every non-IDLE state
- `done` out 1: one-cycle pulse on exit from the final state

## Operation
- States: IDLE → W_FILL → W_LOAD → GAP → A_STREAM → DRAIN → (next pass ? W_FILL : ACC) → IDLE.
- Pass counter k runs 0..n_kij-1. `num_act` and `n_kij` are latched at start; later changes are ignored.
- **W_FILL**
  - Issues xmem reads at w_base + k·col + j, j = 0..col-1.
  - Data returns 1 cycle later into a 1-entry skid register.
  - The skid register is written to L0 (inst[2] = 1) in any cycle where l0_o_full = 0.
  - A new read is issued only if the skid register will be empty in the next cycle.
  - Exits after col L0 writes.
- **W_LOAD**
  - Asserts inst[3] = 1 and inst[0] = 1 for exactly col cycles.
- **GAP**
  - One idle cycle (inst = 0) separating load from execute.
- **A_STREAM**
  - Reads xmem at a_base + k·num_act + i, i = 0..num_act-1, with the same skid/L0-write rule as W_FILL.
  - From the cycle after the first L0 write, asserts inst[3] = 1 and inst[1] = 1 whenever L0 holds at least 1 vector.
  - Ends after num_act L0 reads.
- **Concurrent drain** (active in A_STREAM and DRAIN)
  - Whenever ofifo_o_valid = 1, same cycle: inst[6] = 1, pmem_cen = 0, pmem_wen = 0, pmem_wsel = 0, pmem_addr = k·num_act + d.
  - d counts drained rows, 0..num_act-1.
- **DRAIN**
  - Remains until d = num_act, then increments k.
- **ACC**
  - For each output o = 0..num_act-1:
    - Issue pmem reads (pmem_cen = 0, pmem_wen = 1) at k'·num_act + o for k' = 0..n_kij-1.
    - inst[33] = 1 on each data-return cycle (1 cycle after each read).
    - Then one cycle with inst[33] = 0, during which pmem writes the SFP results at n_kij·num_act + o (pmem_wsel = 1, pmem_wen = 0).
  - After the last o: done = 1, go to IDLE.
- Address arithmetic is modulo 2^addr_w; wrap-around is silent.

## Timing
- Reset values: state IDLE, inst = 0, xmem_cen = 1, pmem_cen = 1, pmem_wen = 1, all addresses 0, pmem_wsel = 0, busy = 0, done = 0, all counters 0.
- Reset mid-operation returns to IDLE next cycle; in-flight skid data is discarded.
- `start` is sampled only in IDLE; busy = 1 from the cycle after start.
- `start` while busy is ignored.
- W_LOAD is exactly col cycles; GAP is exactly 1 cycle.
- With l0_o_full held at 0, W_FILL takes col+1 cycles (1-cycle read latency).
- OFIFO read and pmem write occur in the same cycle; OFIFO out is combinational from its head.
- ACC takes num_act·(n_kij+2) cycles.
- A pmem read issued in cycle t returns data to the SFP in cycle t+1.
- Priority: drain and ACC writes never collide, since they are in disjoint states.

## Test plan
- **Reset:** reset mid-A_STREAM → next cycle busy = 0, inst = 0, xmem_cen = 1; a following start with num_act = 4, n_kij = 1 runs cleanly.
- **Single pass:** n_kij = 1, num_act = 4, w_base = 0, a_base = 16, l0_o_full = 0 →
  - xmem reads 0..7, then 16..19;
  - inst[0] high for 8 cycles;
  - 4 pmem writes at 0..3;
  - ACC writes at 4..7;
  - done pulses once.
- **L0 backpressure:** hold l0_o_full = 1 for 3 cycles in W_FILL → no lost or duplicated weight; exactly 8 L0 writes, with addresses in order.
- **Multi-pass:** n_kij = 3, num_act = 2 →
  - partial sums written at 0..5;
  - ACC read order 0, 2, 4, then 1, 3, 5;
  - inst[33] high 3 cycles per output;
  - results written at 6 and 7.
- **Zero and ignored inputs:** num_act = 0, n_kij = 0 behaves as 1, 1; a start pulse while busy has no effect.
